trng_collector: RTL



---
 rtl/trng_pkg.sv | 32 +++
 rtl/trng_vn_debias.sv | 52 +++++
 rtl/trng_collector.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// trng_pkg : shared state encoding, default parameters and width helper
//            for the TRNG collector.
// Rev 1.0
// ============================================================================
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    FAULT   = 2'd3
  } trng_state_t;

  localparam int c_DEF_WORD_WIDTH    = 32;
  localparam int c_DEF_FIFO_DEPTH    = 2;
  localparam int c_DEF_WARMUP_CYCLES = 64;
  localparam int c_DEF_RCT_CUTOFF    = 32;

  // Width of a counter that must index n distinct values (0..n-1), never below 1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold the value n itself (0..n).
  function automatic int sat_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trng_vn_debias.sv
`default_nettype none
// ============================================================================
// trng_vn_debias : von Neumann corrector, 01 -> 0, 10 -> 1, 00/11 dropped.
// Rev 1.0
// ============================================================================
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic sample_en,
  input  logic raw_bit,
  output logic bit_valid,
  output logic bit_out
);

  logic phase_q, phase_d;
  logic held_q,  held_d;

  always_comb begin
    phase_d = phase_q;
    held_d  = held_q;
    if (clear) begin
      phase_d = 1'b0;
      held_d  = 1'b0;
    end else if (sample_en) begin
      if (!phase_q) begin
        held_d  = raw_bit;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      held_q  <= held_d;
    end
  end

  // The first bit of an unequal pair is the output bit.
  assign bit_valid = sample_en && !clear && phase_q && (held_q != raw_bit);
  assign bit_out   = held_q;

endmodule
`default_nettype wire

// File: rtl/trng_collector.sv
`default_nettype none
// ============================================================================
// trng_collector : TRNG warm-up, debias, repetition-count test, word packing
//                  and a small valid/ready word FIFO.
// Rev 1.0
// ============================================================================
module trng_collector
  import trng_pkg::*;
#(
  parameter int WORD_WIDTH    = c_DEF_WORD_WIDTH,
  parameter int FIFO_DEPTH    = c_DEF_FIFO_DEPTH,
  parameter int WARMUP_CYCLES = c_DEF_WARMUP_CYCLES,
  parameter int RCT_CUTOFF    = c_DEF_RCT_CUTOFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  trng_en,
  input  logic                  trng_out,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  health_fail,
  output logic                  busy
);

  localparam int c_WARM_W = cnt_w(WARMUP_CYCLES);
  localparam int c_RCT_W  = sat_w(RCT_CUTOFF);
  localparam int c_BIT_W  = cnt_w(WORD_WIDTH);
  localparam int c_PTR_W  = cnt_w(FIFO_DEPTH);
  localparam int c_CNT_W  = sat_w(FIFO_DEPTH);

  localparam logic [c_WARM_W-1:0] c_WARM_LAST = c_WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [c_RCT_W-1:0]  c_RCT_TRIP  = c_RCT_W'(RCT_CUTOFF);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WORD_WIDTH - 1);
  localparam logic [c_CNT_W-1:0]  c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);

  trng_state_t           state_q, state_d;
  logic [c_WARM_W-1:0]   warm_q, warm_d;
  logic [c_RCT_W-1:0]    rct_cnt_q, rct_cnt_d;
  logic                  rct_bit_q, rct_bit_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [c_BIT_W-1:0]    bcnt_q, bcnt_d;

  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    wptr_q, rptr_q;
  logic [c_CNT_W-1:0]    count_q, count_d;

  logic                  w_busy;
  logic                  w_rct_sample;
  logic                  w_trip;
  logic                  w_full;
  logic                  w_sample;
  logic                  w_vn_clear;
  logic                  w_bit_valid;
  logic                  w_bit_out;
  logic                  w_push;
  logic                  w_pop;
  logic [WORD_WIDTH-1:0] w_push_word;

  assign w_busy = (state_q == WARMUP) || (state_q == COLLECT);
  assign w_full = (count_q == c_FIFO_FULL);
  assign w_pop  = (count_q != '0) && rready;

  // The first WARMUP cycle sees a sample taken before the oscillators started.
  assign w_rct_sample = enable &&
                        (((state_q == WARMUP) && (warm_q != '0)) || (state_q == COLLECT));

  always_comb begin
    rct_cnt_d = rct_cnt_q;
    rct_bit_d = rct_bit_q;
    if (!w_busy || !enable) begin
      rct_cnt_d = '0;
      rct_bit_d = 1'b0;
    end else if (w_rct_sample) begin
      rct_bit_d = trng_out;
      if ((rct_cnt_q != '0) && (trng_out == rct_bit_q)) begin
        if (rct_cnt_q != c_RCT_TRIP) begin
          rct_cnt_d = rct_cnt_q + 1'b1;
        end
      end else begin
        rct_cnt_d = c_RCT_W'(1);
      end
    end
  end

  assign w_trip     = w_rct_sample && (rct_cnt_d == c_RCT_TRIP);
  assign w_sample   = (state_q == COLLECT) && enable && !w_full && !w_trip;
  assign w_vn_clear = !((state_q == COLLECT) && enable) || w_trip;

  trng_vn_debias u_vn_debias (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (w_vn_clear),
    .sample_en (w_sample),
    .raw_bit   (trng_out),
    .bit_valid (w_bit_valid),
    .bit_out   (w_bit_out)
  );

  assign w_push_word = {shift_q[WORD_WIDTH-2:0], w_bit_out};

  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    w_push  = 1'b0;
    if (w_vn_clear) begin
      shift_d = '0;
      bcnt_d  = '0;
    end else if (w_bit_valid) begin
      if (bcnt_q == c_BIT_LAST) begin
        w_push  = 1'b1;
        shift_d = '0;
        bcnt_d  = '0;
      end else begin
        shift_d = w_push_word;
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = '0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = WARMUP;
      end
      WARMUP: begin
        warm_d = warm_q + 1'b1;
        if (!enable)                    state_d = IDLE;
        else if (w_trip)                state_d = FAULT;
        else if (warm_q == c_WARM_LAST) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable)     state_d = IDLE;
        else if (w_trip) state_d = FAULT;
      end
      FAULT: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      warm_q    <= '0;
      rct_cnt_q <= '0;
      rct_bit_q <= 1'b0;
      shift_q   <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      rct_cnt_q <= rct_cnt_d;
      rct_bit_q <= rct_bit_d;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (w_trip) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) begin
        mem_q[wptr_q] <= w_push_word;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (w_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rvalid      = (count_q != '0);
  assign rdata       = rvalid ? mem_q[rptr_q] : '0;
  assign trng_en     = w_busy;
  assign busy        = w_busy;
  assign health_fail = (state_q == FAULT);

endmodule
`default_nettype wire
